uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sampler.sv | 55 +++++
 rtl/uart_rx_cfg.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM states, parity modes
// and the parity helper used by the frame checker.
package uart_pkg;

   typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} state_t;

   typedef enum logic [2:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE} parity_t;

   // Even-parity bit over a zero-padded word, so every DataBits up to 9 fits.
   function automatic logic parity_calc(input logic [8:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd synchroniser, oversample tick counter and 3-sample majority vote around
// mid-bit. Strobes are qualified by the oversample tick.
module uart_rx_sampler #(
   parameter int OversampleRate = 16,
   parameter int SyncStages     = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic i_tick,
   input  logic i_rxd,
   input  logic i_restart,
   output logic o_rxd_sync,
   output logic o_decide_stb,
   output logic o_bit_val,
   output logic o_bit_end_stb
);
   import uart_pkg::*;

   localparam int TCW = $clog2(OversampleRate);
   localparam logic [TCW-1:0] TC_MID  = TCW'(OversampleRate / 2);
   localparam logic [TCW-1:0] TC_LAST = TCW'(OversampleRate - 1);

   logic [SyncStages-1:0] r_sync;
   logic [TCW-1:0]        r_tc;
   logic [TCW-1:0]        w_tc;
   logic                  r_s_early;
   logic                  r_s_mid;

   assign o_rxd_sync = r_sync[SyncStages-1];

   // Index of the tick being consumed now; restart makes it tick 0 of a bit.
   assign w_tc = (i_restart || r_tc == TC_LAST) ? '0 : r_tc + 1'b1;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_sync    <= '1;
         r_tc      <= TC_LAST;
         r_s_early <= 1'b1;
         r_s_mid   <= 1'b1;
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], i_rxd};
         if (i_tick) begin
            r_tc <= w_tc;
            if (w_tc == TC_MID - 1'b1) r_s_early <= o_rxd_sync;
            if (w_tc == TC_MID)        r_s_mid   <= o_rxd_sync;
         end
      end
   end

   assign o_decide_stb  = i_tick && (w_tc == TC_MID + 1'b1);
   assign o_bit_end_stb = i_tick && (w_tc == TC_LAST);
   assign o_bit_val     = (r_s_early & r_s_mid) | (r_s_early & o_rxd_sync) |
                          (r_s_mid & o_rxd_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, selectable parity, 1/2 stop bits,
// break detection and a valid/ready output register with overrun pulse.
module uart_rx_cfg #(
   parameter int    DataBits       = 8,
   parameter string ParityBit      = "none",
   parameter int    StopBits       = 1,
   parameter int    OversampleRate = 16,
   parameter int    SyncStages     = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                uart_clk_en_i,
   input  logic                uart_rxd_i,
   output logic [DataBits-1:0] data_o,
   output logic                data_valid_o,
   input  logic                data_ready_i,
   output logic                frame_error_o,
   output logic                parity_error_o,
   output logic                overrun_o,
   output logic                break_o,
   output logic                busy_o
);
   import uart_pkg::*;

   localparam int BCW = $clog2(DataBits);
   localparam parity_t PAR = (ParityBit == "even")  ? PAR_EVEN  :
                             (ParityBit == "odd")   ? PAR_ODD   :
                             (ParityBit == "mark")  ? PAR_MARK  :
                             (ParityBit == "space") ? PAR_SPACE : PAR_NONE;
   localparam bit PAR_EN = (PAR != PAR_NONE);

   if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
      $error("uart_rx_cfg: DataBits must be 5..9");
   end
   if (!(ParityBit == "none" || ParityBit == "even" || ParityBit == "odd" ||
         ParityBit == "mark" || ParityBit == "space")) begin : g_bad_parity
      $error("uart_rx_cfg: ParityBit must be none/even/odd/mark/space");
   end
   if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
      $error("uart_rx_cfg: StopBits must be 1 or 2");
   end
   if (OversampleRate < 8 || (OversampleRate % 2) != 0) begin : g_bad_osr
      $error("uart_rx_cfg: OversampleRate must be even and >= 8");
   end
   if (SyncStages < 2) begin : g_bad_sync
      $error("uart_rx_cfg: SyncStages must be >= 2");
   end

   state_t              r_state, w_state_nxt;
   logic [DataBits-1:0] r_shift;
   logic [BCW-1:0]      r_bitcnt;
   logic                r_stopcnt, r_stop1, r_par_bit, r_par_err, r_frm_err;
   logic                w_rxd, w_decide, w_bit_val, w_bit_end, w_restart;
   logic                w_commit, w_break, w_last_stop, w_stop1, w_is_break, w_exp_par;
   logic [DataBits-1:0] r_data;
   logic                r_valid, r_ferr, r_perr, r_overrun, r_break;

   uart_rx_sampler #(.OversampleRate(OversampleRate), .SyncStages(SyncStages)) u_sampler (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .i_tick       (uart_clk_en_i),
      .i_rxd        (uart_rxd_i),
      .i_restart    (w_restart),
      .o_rxd_sync   (w_rxd),
      .o_decide_stb (w_decide),
      .o_bit_val    (w_bit_val),
      .o_bit_end_stb(w_bit_end)
   );

   always_comb begin
      case (PAR)
         PAR_EVEN:  w_exp_par = parity_calc(9'(r_shift));
         PAR_ODD:   w_exp_par = ~parity_calc(9'(r_shift));
         PAR_MARK:  w_exp_par = 1'b1;
         default:   w_exp_par = 1'b0;
      endcase
   end

   assign w_last_stop = (r_stopcnt == 1'(StopBits - 1));
   assign w_stop1     = (r_stopcnt == 1'b0) ? w_bit_val : r_stop1;
   assign w_is_break  = (r_shift == '0) && (!PAR_EN || !r_par_bit) && !w_stop1;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= WAIT_HIGH;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_commit    = 1'b0;
      w_break     = 1'b0;
      case (r_state)
         WAIT_HIGH: if (uart_clk_en_i && w_rxd) w_state_nxt = IDLE;
         IDLE: if (uart_clk_en_i && !w_rxd) begin
            w_state_nxt = START;
            w_restart   = 1'b1;
         end
         START: begin
            if (w_decide && w_bit_val) w_state_nxt = IDLE;
            else if (w_bit_end)        w_state_nxt = DATA;
         end
         DATA: if (w_bit_end && r_bitcnt == BCW'(DataBits - 1))
            w_state_nxt = PAR_EN ? PARITY : STOP;
         PARITY: if (w_bit_end) w_state_nxt = STOP;
         STOP: if (w_decide && w_last_stop) begin
            // Leave mid-bit so the next start edge is caught with margin.
            w_state_nxt = w_is_break ? WAIT_HIGH : IDLE;
            w_break     = w_is_break;
            w_commit    = !w_is_break;
         end
         default: w_state_nxt = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_stop1   <= 1'b0;
         r_par_bit <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         case (r_state)
            START: begin
               r_bitcnt  <= '0;
               r_stopcnt <= 1'b0;
               r_par_bit <= 1'b0;
               r_par_err <= 1'b0;
               r_frm_err <= 1'b0;
            end
            DATA: begin
               if (w_decide)  r_shift  <= {w_bit_val, r_shift[DataBits-1:1]};
               if (w_bit_end) r_bitcnt <= r_bitcnt + 1'b1;
            end
            PARITY: if (w_decide) begin
               r_par_bit <= w_bit_val;
               r_par_err <= (w_bit_val != w_exp_par);
            end
            STOP: begin
               if (w_decide) begin
                  r_frm_err <= r_frm_err | ~w_bit_val;
                  if (r_stopcnt == 1'b0) r_stop1 <= w_bit_val;
               end
               if (w_bit_end) r_stopcnt <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Output register: a commit in the accept cycle replaces the word.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_break   <= w_break;
         if (w_commit) begin
            if (r_valid && !data_ready_i) begin
               r_overrun <= 1'b1;
            end else begin
               r_data  <= r_shift;
               r_ferr  <= r_frm_err | ~w_bit_val;
               r_perr  <= r_par_err;
               r_valid <= 1'b1;
            end
         end else if (r_valid && data_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o         = r_data;
   assign data_valid_o   = r_valid;
   assign frame_error_o  = r_ferr;
   assign parity_error_o = r_perr;
   assign overrun_o      = r_overrun;
   assign break_o        = r_break;
   assign busy_o         = !(r_state == IDLE || r_state == WAIT_HIGH);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: dut A is 8N1 @16x, dut B is 7O2 @8x with 3 sync stages.
module tb_uart_rx_cfg;

   typedef struct packed {
      logic [8:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] tcnt = 2'd0;
   logic       tick;
   logic       rxd_a = 1'b1, rxd_b = 1'b1;
   logic       ready_a = 1'b1, ready_b = 1'b1;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       valid_a, fe_a, pe_a, ovr_a, brk_a, busy_a;
   logic       valid_b, fe_b, pe_b, ovr_b, brk_b, busy_b;

   exp_t q_a[$], q_b[$];
   int   checks = 0, errors = 0;
   int   exp_brk_a = 0, exp_brk_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;
   int   vcyc_a = 0;
   bit   rnd_rdy = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) tcnt <= tcnt + 2'd1;
   assign tick = (tcnt == 2'd3);

   uart_rx_cfg #(.DataBits(8), .ParityBit("none"), .StopBits(1),
                 .OversampleRate(16), .SyncStages(2)) u_dut_a (
      .clk_i(clk), .reset_i(rst), .uart_clk_en_i(tick), .uart_rxd_i(rxd_a),
      .data_o(data_a), .data_valid_o(valid_a), .data_ready_i(ready_a),
      .frame_error_o(fe_a), .parity_error_o(pe_a), .overrun_o(ovr_a),
      .break_o(brk_a), .busy_o(busy_a));

   uart_rx_cfg #(.DataBits(7), .ParityBit("odd"), .StopBits(2),
                 .OversampleRate(8), .SyncStages(3)) u_dut_b (
      .clk_i(clk), .reset_i(rst), .uart_clk_en_i(tick), .uart_rxd_i(rxd_b),
      .data_o(data_b), .data_valid_o(valid_b), .data_ready_i(ready_b),
      .frame_error_o(fe_b), .parity_error_o(pe_b), .overrun_o(ovr_b),
      .break_o(brk_b), .busy_o(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic bad(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Reference: what a receiver must report for a given transmitted frame.
   function automatic void model(input bit b, input logic [8:0] d, input bit pflip,
                                 input bit s1, input bit s2, output exp_t e,
                                 output bit brk, output bit pbit);
      logic [8:0] dm;
      dm   = b ? (d & 9'h07F) : (d & 9'h0FF);
      pbit = (($countones(dm) % 2) == 0) ^ pflip;
      e.data = dm;
      e.pe   = b & pflip;
      e.fe   = !s1 || (b && !s2);
      brk    = (dm == 9'd0) && (!b || !pbit) && !s1;
   endfunction

   task automatic slot(input bit b, input logic v);
      if (b) rxd_b = v; else rxd_a = v;
      @(negedge clk);
      while (!tick) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic slots(input bit b, input logic v, input int n);
      repeat (n) slot(b, v);
   endtask

   task automatic send_frame(input bit b, input logic [8:0] d, input bit pflip,
                             input bit s1, input bit s2, input int glitch,
                             input bit push, input int gap);
      exp_t e;
      bit   brk, pbit, v;
      bit   bits[$];
      int   osr, nd;
      osr = b ? 8 : 16;
      nd  = b ? 7 : 8;
      model(b, d, pflip, s1, s2, e, brk, pbit);
      if (push) begin
         if (brk) begin
            if (b) exp_brk_b++; else exp_brk_a++;
         end else if (b) q_b.push_back(e);
         else            q_a.push_back(e);
      end
      bits.push_back(1'b0);
      for (int i = 0; i < nd; i++) bits.push_back(d[i]);
      if (b) bits.push_back(pbit);
      bits.push_back(s1);
      if (b) bits.push_back(s2);
      for (int j = 0; j < bits.size(); j++)
         for (int k = 0; k < osr; k++) begin
            v = bits[j];
            if (j * osr + k == glitch) v = !v;
            slot(b, v);
         end
      slots(b, 1'b1, gap);
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst) begin
         if (valid_a) vcyc_a++;
         if (valid_a && ready_a) begin
            if (q_a.size() == 0) bad("a_unexpected_word");
            else begin
               e = q_a.pop_front();
               chk("a_data", {24'd0, data_a}, {23'd0, e.data});
               chk("a_frame_err", {31'd0, fe_a}, {31'd0, e.fe});
               chk("a_parity_err", {31'd0, pe_a}, {31'd0, e.pe});
            end
         end
         if (brk_a) begin
            if (exp_brk_a > 0) begin exp_brk_a--; checks++; end
            else bad("a_unexpected_break");
         end
         if (ovr_a) begin
            if (exp_ovr_a > 0) begin exp_ovr_a--; checks++; end
            else bad("a_unexpected_overrun");
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst) begin
         if (valid_b && ready_b) begin
            if (q_b.size() == 0) bad("b_unexpected_word");
            else begin
               e = q_b.pop_front();
               chk("b_data", {25'd0, data_b}, {23'd0, e.data});
               chk("b_frame_err", {31'd0, fe_b}, {31'd0, e.fe});
               chk("b_parity_err", {31'd0, pe_b}, {31'd0, e.pe});
            end
         end
         if (brk_b) begin
            if (exp_brk_b > 0) begin exp_brk_b--; checks++; end
            else bad("b_unexpected_break");
         end
         if (ovr_b) begin
            if (exp_ovr_b > 0) begin exp_ovr_b--; checks++; end
            else bad("b_unexpected_overrun");
         end
      end
   end

   initial begin : rdy_drv
      forever begin
         @(posedge clk);
         #2;
         if (rnd_rdy) begin
            ready_a = 1'($urandom_range(0, 1));
            ready_b = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin : main
      int v0, n;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs_a", {24'd0, data_a, valid_a, fe_a, pe_a, ovr_a, brk_a, busy_a}, 0);
      chk("reset_outputs_b", {25'd0, data_b, valid_b, fe_b, pe_b, ovr_b, brk_b, busy_b}, 0);
      rst = 1'b0;
      slots(0, 1'b1, 4);

      // 8N1 0xA5, valid held exactly one clock with ready high
      v0 = vcyc_a;
      send_frame(0, 9'h0A5, 0, 1, 1, -1, 1, 20);
      chk("t1_valid_cycles", vcyc_a - v0, 1);

      // 7O2: parity error, then second stop bit low
      send_frame(1, 9'h037, 1, 1, 1, -1, 1, 20);
      send_frame(1, 9'h055, 0, 1, 0, -1, 1, 20);

      // false start, then a mid-bit glitch that the vote must reject
      slots(0, 1'b0, 5);
      chk("t3_busy_in_start", {31'd0, busy_a}, 1);
      slots(0, 1'b1, 16);
      chk("t3_busy_after_false_start", {31'd0, busy_a}, 0);
      send_frame(0, 9'h0FF, 0, 1, 1, 16 * 4 + 8, 1, 20);

      // overrun: second word dropped while the first is held
      ready_a = 1'b0;
      send_frame(0, 9'h011, 0, 1, 1, -1, 1, 20);
      chk("t4_held_first", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'h11});
      exp_ovr_a++;
      send_frame(0, 9'h022, 0, 1, 1, -1, 0, 20);
      chk("t4_still_first", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'h11});
      chk("t4_overrun_pulses_left", exp_ovr_a, 0);
      ready_a = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_valid_dropped", {31'd0, valid_a}, 0);

      // break: 12 bit times low
      exp_brk_a++;
      slots(0, 1'b0, 192);
      chk("t5_break_pulses_left", exp_brk_a, 0);
      chk("t5_idle_while_low", {30'd0, busy_a, valid_a}, 0);
      slots(0, 1'b1, 20);
      send_frame(0, 9'h05A, 0, 1, 1, -1, 1, 20);

      // reset mid-frame with a word held
      ready_a = 1'b0;
      send_frame(0, 9'h077, 0, 1, 1, -1, 0, 20);
      chk("t6_word_held", {31'd0, valid_a}, 1);
      slots(0, 1'b0, 16);
      slots(0, 1'b1, 72);
      chk("t6_busy_before_reset", {31'd0, busy_a}, 1);
      rst = 1'b1;
      #1;
      chk("t6_reset_outputs", {24'd0, data_a, valid_a, fe_a, pe_a, ovr_a, brk_a, busy_a}, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ready_a = 1'b1;
      slots(0, 1'b1, 72 + 20);
      send_frame(0, 9'h03C, 0, 1, 1, -1, 1, 20);

      // randomized frames on both receivers, random consumer stalls
      rnd_rdy = 1'b1;
      for (int i = 0; i < 30; i++) begin
         logic [8:0] d;
         d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
         send_frame(1'($urandom_range(0, 1)), d, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, -1, 1,
                    $urandom_range(20, 40));
      end
      rnd_rdy = 1'b0;
      #3;
      ready_a = 1'b1;
      ready_b = 1'b1;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("end_queue_a_empty", q_a.size(), 0);
      chk("end_queue_b_empty", q_b.size(), 0);
      chk("end_breaks_seen", exp_brk_a + exp_brk_b, 0);
      chk("end_overruns_seen", exp_ovr_a + exp_ovr_b, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
